exm: RTL

//  Execute stage of the DPROC pipeline. Consumes decoded operations (ALU_* / BRANCH_* codes) from decode.

---
 rtl/ecap5_dproc_pkg.sv | 25 ++
 rtl/exm_shifter.sv | 47 ++++
 rtl/exm.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ecap5_dproc_pkg.sv
// Shared encodings for the DPROC pipeline: ALU and branch codes, widths, and execute-stage states.
package ecap5_dproc_pkg;

  localparam int DATA_W      = 32;
  localparam int SHAMT_WIDTH = 5;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_XOR   = 3'd1;
  localparam logic [2:0] ALU_OR    = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_SLT   = 3'd4;
  localparam logic [2:0] ALU_SLTU  = 3'd5;
  localparam logic [2:0] ALU_SHIFT = 3'd6;

  localparam logic [2:0] NO_BRANCH   = 3'd0;
  localparam logic [2:0] BRANCH_BEQ  = 3'd1;
  localparam logic [2:0] BRANCH_BNE  = 3'd2;
  localparam logic [2:0] BRANCH_BLT  = 3'd3;
  localparam logic [2:0] BRANCH_BLTU = 3'd4;
  localparam logic [2:0] BRANCH_BGE  = 3'd5;
  localparam logic [2:0] BRANCH_BGEU = 3'd6;

  typedef enum logic [1:0] {EXM_IDLE, EXM_SHIFT} exm_state_t;

endpackage

// File: rtl/exm_shifter.sv
// Serial 1-bit-per-cycle shifter: loads on start, shifts while the counter is non-zero.
module exm_shifter
  import ecap5_dproc_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   start_i,
  input  logic [DATA_W-1:0]      data_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  input  logic                   left_i,
  input  logic                   arith_i,
  output logic [DATA_W-1:0]      result_o,
  output logic                   done_o
);

  logic signed [DATA_W-1:0]  work_p1;
  logic [SHAMT_WIDTH-1:0]    cnt_p1;
  logic                      left_p1;
  logic                      arith_p1;

  // p0 -> p1: load on start, then one bit per cycle until the counter drains
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      work_p1  <= '0;
      cnt_p1   <= '0;
      left_p1  <= 1'b0;
      arith_p1 <= 1'b0;
    end else if (start_i) begin
      work_p1  <= data_i;
      cnt_p1   <= shamt_i;
      left_p1  <= left_i;
      arith_p1 <= arith_i;
    end else if (cnt_p1 != '0) begin
      cnt_p1 <= cnt_p1 - 1'b1;
      if (left_p1)
        work_p1 <= work_p1 <<< 1;
      else if (arith_p1)
        work_p1 <= work_p1 >>> 1;
      else
        work_p1 <= work_p1 >> 1;
    end
  end

  assign result_o = work_p1;
  assign done_o   = (cnt_p1 == '0);

endmodule

// File: rtl/exm.sv
// DPROC execute stage: single-cycle ALU and branch resolution, serial shifter for ALU_SHIFT,
// one-entry registered output with valid/ready on both sides.
module exm
  import ecap5_dproc_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              input_valid_i,
  output logic              input_ready_o,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] alu_operand1_i,
  input  logic [DATA_W-1:0] alu_operand2_i,
  input  logic [2:0]        alu_op_i,
  input  logic              alu_sub_i,
  input  logic              alu_shift_left_i,
  input  logic              alu_shift_arith_i,
  input  logic [2:0]        branch_cond_i,
  input  logic [DATA_W-1:0] branch_offset_i,
  input  logic              reg_write_i,
  input  logic [4:0]        reg_addr_i,
  output logic              output_valid_o,
  input  logic              output_ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              reg_write_o,
  output logic [4:0]        reg_addr_o,
  output logic              branch_o,
  output logic [DATA_W-1:0] branch_target_o
);

  function automatic logic [DATA_W-1:0] alu_eval(input logic [2:0] op, input logic sub,
                                                 input logic signed [DATA_W-1:0] a,
                                                 input logic signed [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    r = '0;
    case (op)
      ALU_ADD:   r = sub ? a - b : a + b;
      ALU_XOR:   r = a ^ b;
      ALU_OR:    r = a | b;
      ALU_AND:   r = a & b;
      ALU_SLT:   r = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_SLTU:  r = {{(DATA_W-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
      ALU_SHIFT: r = a;
      default:   r = '0;
    endcase
    return r;
  endfunction

  function automatic logic branch_eval(input logic [2:0] cond,
                                       input logic signed [DATA_W-1:0] a,
                                       input logic signed [DATA_W-1:0] b);
    logic t;
    t = 1'b0;
    case (cond)
      BRANCH_BEQ:  t = (a == b);
      BRANCH_BNE:  t = (a != b);
      BRANCH_BLT:  t = (a < b);
      BRANCH_BGE:  t = (a >= b);
      BRANCH_BLTU: t = ($unsigned(a) < $unsigned(b));
      BRANCH_BGEU: t = ($unsigned(a) >= $unsigned(b));
      default:     t = 1'b0;
    endcase
    return t;
  endfunction

  exm_state_t state;

  logic                     ready_en_p1;
  logic                     vld_p1;
  logic [DATA_W-1:0]        result_p1;
  logic                     reg_write_p1;
  logic [4:0]               reg_addr_p1;
  logic                     branch_p1;
  logic [DATA_W-1:0]        target_p1;

  // Side-band fields of an in-flight shift, released with the shift result
  logic                     reg_write_sh;
  logic [4:0]               reg_addr_sh;
  logic                     branch_sh;
  logic [DATA_W-1:0]        target_sh;

  logic signed [DATA_W-1:0] op1_p0;
  logic signed [DATA_W-1:0] op2_p0;
  logic [SHAMT_WIDTH-1:0]   shamt_p0;
  logic                     out_free;
  logic                     accept_p0;
  logic                     shift_start_p0;
  logic [DATA_W-1:0]        alu_p0;
  logic                     branch_p0;
  logic [DATA_W-1:0]        target_p0;
  logic [DATA_W-1:0]        shift_result;
  logic                     shift_done;

  assign op1_p0         = alu_operand1_i;
  assign op2_p0         = alu_operand2_i;
  assign shamt_p0       = alu_operand2_i[SHAMT_WIDTH-1:0];
  assign out_free       = ~vld_p1 | output_ready_i;
  assign input_ready_o  = ready_en_p1 & (state == EXM_IDLE) & out_free;
  assign accept_p0      = input_valid_i & input_ready_o;
  assign shift_start_p0 = accept_p0 & (alu_op_i == ALU_SHIFT) & (shamt_p0 != '0);
  assign alu_p0         = alu_eval(alu_op_i, alu_sub_i, op1_p0, op2_p0);
  assign branch_p0      = branch_eval(branch_cond_i, op1_p0, op2_p0);
  assign target_p0      = pc_i + branch_offset_i;

  exm_shifter u_shifter (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .start_i  (shift_start_p0),
    .data_i   (alu_operand1_i),
    .shamt_i  (shamt_p0),
    .left_i   (alu_shift_left_i),
    .arith_i  (alu_shift_arith_i),
    .result_o (shift_result),
    .done_o   (shift_done)
  );

  // p0 -> p1: output slot load, from the ALU on accept or from the shifter on completion
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= EXM_IDLE;
      ready_en_p1  <= 1'b0;
      vld_p1       <= 1'b0;
      result_p1    <= '0;
      reg_write_p1 <= 1'b0;
      reg_addr_p1  <= '0;
      branch_p1    <= 1'b0;
      target_p1    <= '0;
      reg_write_sh <= 1'b0;
      reg_addr_sh  <= '0;
      branch_sh    <= 1'b0;
      target_sh    <= '0;
    end else begin
      ready_en_p1 <= 1'b1;
      if (vld_p1 && output_ready_i)
        vld_p1 <= 1'b0;
      case (state)
        EXM_IDLE: begin
          if (shift_start_p0) begin
            state        <= EXM_SHIFT;
            reg_write_sh <= reg_write_i;
            reg_addr_sh  <= reg_addr_i;
            branch_sh    <= branch_p0;
            target_sh    <= target_p0;
          end else if (accept_p0) begin
            vld_p1       <= 1'b1;
            result_p1    <= alu_p0;
            reg_write_p1 <= reg_write_i;
            reg_addr_p1  <= reg_addr_i;
            branch_p1    <= branch_p0;
            target_p1    <= target_p0;
          end
        end
        EXM_SHIFT: begin
          if (shift_done && out_free) begin
            state        <= EXM_IDLE;
            vld_p1       <= 1'b1;
            result_p1    <= shift_result;
            reg_write_p1 <= reg_write_sh;
            reg_addr_p1  <= reg_addr_sh;
            branch_p1    <= branch_sh;
            target_p1    <= target_sh;
          end
        end
        default: state <= EXM_IDLE;
      endcase
    end
  end

  assign output_valid_o  = vld_p1;
  assign result_o        = result_p1;
  assign reg_write_o     = reg_write_p1;
  assign reg_addr_o      = reg_addr_p1;
  assign branch_o        = branch_p1;
  assign branch_target_o = target_p1;

endmodule
